// File: rtl/note_player_pkg.sv
// Shared types and widths for the note player: FSM state encoding and datapath sizes.
package note_player_pkg;

  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 7;
  localparam int STEP_W     = 20;
  localparam int PHASE_W    = 22;
  localparam int ADDR_W     = 10;
  localparam int SMP_STAGES = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

endpackage

// File: rtl/frequency_rom.sv
// Note index -> phase step ROM, round(440*2^((n-49)/12)*2^22/48000); read is registered
// and only advances on en so the step holds for the life of a note.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NOTE_W-1:0] addr,
  output logic [STEP_W-1:0] step
);

  logic [STEP_W-1:0] rom_val;

  always_comb begin
    rom_val = '0;
    case (addr)
      6'd1:  rom_val = 20'd2403;   6'd2:  rom_val = 20'd2546;   6'd3:  rom_val = 20'd2697;
      6'd4:  rom_val = 20'd2858;   6'd5:  rom_val = 20'd3028;   6'd6:  rom_val = 20'd3208;
      6'd7:  rom_val = 20'd3398;   6'd8:  rom_val = 20'd3600;   6'd9:  rom_val = 20'd3815;
      6'd10: rom_val = 20'd4041;   6'd11: rom_val = 20'd4282;   6'd12: rom_val = 20'd4536;
      6'd13: rom_val = 20'd4806;   6'd14: rom_val = 20'd5092;   6'd15: rom_val = 20'd5395;
      6'd16: rom_val = 20'd5715;   6'd17: rom_val = 20'd6055;   6'd18: rom_val = 20'd6415;
      6'd19: rom_val = 20'd6797;   6'd20: rom_val = 20'd7201;   6'd21: rom_val = 20'd7629;
      6'd22: rom_val = 20'd8083;   6'd23: rom_val = 20'd8563;   6'd24: rom_val = 20'd9072;
      6'd25: rom_val = 20'd9612;   6'd26: rom_val = 20'd10184;  6'd27: rom_val = 20'd10789;
      6'd28: rom_val = 20'd11431;  6'd29: rom_val = 20'd12110;  6'd30: rom_val = 20'd12830;
      6'd31: rom_val = 20'd13593;  6'd32: rom_val = 20'd14402;  6'd33: rom_val = 20'd15258;
      6'd34: rom_val = 20'd16165;  6'd35: rom_val = 20'd17127;  6'd36: rom_val = 20'd18145;
      6'd37: rom_val = 20'd19224;  6'd38: rom_val = 20'd20367;  6'd39: rom_val = 20'd21578;
      6'd40: rom_val = 20'd22861;  6'd41: rom_val = 20'd24221;  6'd42: rom_val = 20'd25661;
      6'd43: rom_val = 20'd27187;  6'd44: rom_val = 20'd28803;  6'd45: rom_val = 20'd30516;
      6'd46: rom_val = 20'd32331;  6'd47: rom_val = 20'd34253;  6'd48: rom_val = 20'd36290;
      6'd49: rom_val = 20'd38448;  6'd50: rom_val = 20'd40734;  6'd51: rom_val = 20'd43156;
      6'd52: rom_val = 20'd45722;  6'd53: rom_val = 20'd48441;  6'd54: rom_val = 20'd51322;
      6'd55: rom_val = 20'd54373;  6'd56: rom_val = 20'd57607;  6'd57: rom_val = 20'd61032;
      6'd58: rom_val = 20'd64661;  6'd59: rom_val = 20'd68506;  6'd60: rom_val = 20'd72580;
      6'd61: rom_val = 20'd76896;  6'd62: rom_val = 20'd81468;  6'd63: rom_val = 20'd86312;
      default: rom_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     step <= '0;
    else if (en) step <= rom_val;
  end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: counts beats down to note_done and advances a sine-table
// phase accumulator on each sample request while running.
module note_player
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              new_beat,
  input  logic              sample_req,
  output logic              note_done,
  output logic              sample_valid,
  output logic [ADDR_W-1:0] phase_addr,
  output logic              busy
);

  state_t              state, state_nxt;
  logic [DUR_W-1:0]    beat_cnt;
  logic [PHASE_W-1:0]  phase;
  logic [STEP_W-1:0]   step;
  logic [SMP_STAGES-1:0] vld_pipe;
  logic                adv, expire;

  frequency_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (new_note),
    .addr (note),
    .step (step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A load always wins over pause/expiry; play=0 freezes counting on the same edge.
  always_comb begin
    state_nxt = state;
    if (new_note) begin
      state_nxt = play ? ST_PLAYING : ST_PAUSED;
    end else begin
      case (state)
        ST_PLAYING: if (expire) state_nxt = ST_IDLE;
                    else if (!play) state_nxt = ST_PAUSED;
        ST_PAUSED:  if (play) state_nxt = ST_PLAYING;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // duration=0 expires on the first running cycle without needing a beat.
  always_comb begin
    busy   = (state != ST_IDLE);
    adv    = (state == ST_PLAYING) && play && !new_note;
    expire = adv && ((beat_cnt == '0) || (new_beat && (beat_cnt == DUR_W'(1))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      phase     <= '0;
      note_done <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      note_done   <= expire;
      vld_pipe[0] <= sample_req;
      for (int i = 1; i < SMP_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (new_note) begin
        beat_cnt <= duration;
        phase    <= '0;
      end else if (adv) begin
        if (expire)        beat_cnt <= '0;
        else if (new_beat) beat_cnt <= beat_cnt - DUR_W'(1);
        if (sample_req)    phase <= phase + {{(PHASE_W-STEP_W){1'b0}}, step};
      end
    end
  end

  assign sample_valid = vld_pipe[SMP_STAGES-1];
  assign phase_addr   = phase[PHASE_W-1 -: ADDR_W];

endmodule

// File: tb/tb_note_player.sv
// Directed + randomized scoreboard bench for note_player with a behavioural reference model.
module tb_note_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1, play = 1'b0, new_note = 1'b0, new_beat = 1'b0, sample_req = 1'b0;
  logic [5:0] note = '0;
  logic [6:0] duration = '0;
  logic       note_done, sample_valid, busy;
  logic [9:0] phase_addr;

  note_player dut (
    .clk(clk), .rst(rst), .play(play), .new_note(new_note), .note(note),
    .duration(duration), .new_beat(new_beat), .sample_req(sample_req),
    .note_done(note_done), .sample_valid(sample_valid), .phase_addr(phase_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int edge_n; logic [9:0] addr; } sv_t;
  int   nd_q[$];
  sv_t  sv_q[$];
  int   tests = 0, fails = 0;

  int         m_st = 0, m_cnt = 0;
  logic [21:0] m_phase = '0;
  logic [19:0] m_step = '0;

  function automatic logic [19:0] ref_step(input int n);
    real r;
    if (n == 0) return 20'd0;
    r = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 4194304.0 / 48000.0;
    return 20'($rtoi(r + 0.5));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the model, then check outputs 1 ns after the edge.
  task automatic step(input bit r, nn, input int n, d, input bit b, s);
    int  e;
    bit  exp_nd, exp_sv;
    sv_t ent;
    logic [9:0] exp_addr;
    rst = r; new_note = nn; note = 6'(n); duration = 7'(d); new_beat = b; sample_req = s;
    e = cyc + 1;
    if (r) begin
      m_st = 0; m_cnt = 0; m_phase = '0; m_step = '0;
      nd_q.delete(); sv_q.delete();
    end else begin
      if (nn) begin
        m_cnt = d; m_step = ref_step(n); m_phase = '0; m_st = play ? 1 : 2;
      end else if (m_st == 1) begin
        if (play) begin
          if (m_cnt == 0 || (b && m_cnt == 1)) begin
            nd_q.push_back(e); m_st = 0; m_cnt = 0;
          end else if (b) m_cnt--;
          if (s) m_phase = m_phase + {2'b00, m_step};
        end else m_st = 2;
      end else if (m_st == 2) begin
        if (play) m_st = 1;
      end
      if (s) begin
        ent.edge_n = e; ent.addr = m_phase[21:12];
        sv_q.push_back(ent);
      end
    end
    @(posedge clk); #1;
    rst = 0; new_note = 0; new_beat = 0; sample_req = 0;
    exp_nd = (nd_q.size() > 0) && (nd_q[0] == cyc);
    if (exp_nd) void'(nd_q.pop_front());
    check("note_done", 32'(note_done), 32'(exp_nd));
    exp_sv = (sv_q.size() > 0) && (sv_q[0].edge_n == cyc);
    exp_addr = '0;
    if (exp_sv) begin
      ent = sv_q.pop_front();
      exp_addr = ent.addr;
    end
    check("sample_valid", 32'(sample_valid), 32'(exp_sv));
    if (exp_sv) check("sample_addr", 32'(phase_addr), 32'(exp_addr));
    check("busy", 32'(busy), 32'(m_st != 0));
    check("phase_addr", 32'(phase_addr), 32'(m_phase[21:12]));
  endtask

  task automatic idle(input int k);  for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0); endtask
  task automatic beat();             step(0, 0, 0, 0, 1, 0); endtask
  task automatic samp(input int k);  for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 1); endtask
  task automatic load(input int n, d); step(0, 1, n, d, 0, 0); endtask

  initial begin
    int done_cnt;
    // reset state
    play = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // load 49/3, three beats, note_done one cycle after the third
    load(49, 3); idle(2); beat(); idle(2); beat(); idle(1);
    step(0, 0, 0, 0, 1, 0);
    check("done_after_beat3", 32'(note_done), 32'd1);
    check("busy_falls_with_done", 32'(busy), 32'd0);
    idle(3);

    // four samples of A4 -> phase 153792, addr 37
    load(49, 10); samp(4);
    check("phase_addr_4samp", 32'(phase_addr), 32'd37);
    idle(1);

    // pause mid-note: beats and samples ignored, resume and finish
    load(60, 2); samp(2); beat();
    play = 1'b0; idle(1);
    for (int i = 0; i < 5; i++) begin beat(); samp(1); end
    play = 1'b1; idle(2); beat(); idle(2);

    // duration 0 expires on its own
    load(10, 0); idle(3);

    // load coinciding with the expiring beat wins
    load(49, 1); idle(1);
    step(0, 1, 20, 2, 1, 0);
    idle(1); beat(); idle(1); beat(); idle(2);

    // rest: phase stays at zero across samples
    load(0, 4); samp(10); beat(); beat(); beat(); beat(); idle(2);

    // reset mid-note with five beats left, then beats in idle
    load(49, 8); beat(); beat(); beat(); samp(2);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) beat();

    // reset beats a coincident load; first load afterwards behaves normally
    step(1, 1, 49, 3, 1, 1);
    idle(1);
    load(49, 3); beat(); beat(); beat(); idle(2);

    // load while paused, then run
    play = 1'b0; load(49, 2); beat(); samp(1); idle(1);
    play = 1'b1; idle(1); beat(); beat(); idle(2);

    // accumulator wrap with the largest step
    load(63, 100); samp(60); idle(1);

    // ROM sweep: three samples per note
    for (int n = 0; n < 64; n++) begin load(n, 5); samp(3); end

    // randomized traffic
    done_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 40) == 0) play = ~play;
      step($urandom_range(0, 200) == 0, $urandom_range(0, 30) == 0,
           int'($urandom_range(0, 63)), int'($urandom_range(0, 6)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if (note_done) done_cnt++;
    end
    play = 1'b1; idle(2);

    check("nd_queue_drained", 32'(nd_q.size()), 32'd0);
    check("sv_queue_drained", 32'(sv_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The port list SHALL be exactly as follows, clock and reset first; one clock domain; rst is synchronous and active-high.
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- play  input  1  1 = run, 0 = pause (counters and phase frozen)
- new_note  input  1  one-cycle load strobe from song_reader
- note  input  6  note index; 0 = rest, 1..63 = semitones, 49 = A4
- duration  input  7  note length in beats, sampled with new_note
- new_beat  input  1  one-cycle beat tick from beat_generator
- sample_req  input  1  one-cycle request for the next audio sample
- note_done  output  1  one-cycle pulse when the current note expires
- sample_valid  output  1  one-cycle pulse, one cycle after an accepted sample_req
- phase_addr  output  10  sine-table address, equal to phase[21:12]
- busy  output  1  1 while in PLAYING or PAUSED

Function
REQ-002 The state machine SHALL have exactly the states IDLE, PLAYING and PAUSED.
REQ-003 new_note in any state SHALL latch note and duration, set beat_cnt to duration, set step to freq_rom(note), clear phase to 0 and enter PLAYING if play=1, otherwise PAUSED.
REQ-004 The step lookup SHALL be registered at load, so step is valid on the cycle after new_note; there is no combinational path from note to outputs.
REQ-005 In PLAYING, play=0 SHALL move the block to PAUSED on the next edge.
REQ-006 In PAUSED, play=1 SHALL move the block to PLAYING on the next edge.
REQ-007 In PAUSED, beat_cnt and phase SHALL hold, and new_beat and sample_req SHALL be ignored.
REQ-008 In PLAYING, each new_beat SHALL decrement beat_cnt.
REQ-009 When a new_beat arrives with beat_cnt=1, the block SHALL pulse note_done in the next cycle and enter IDLE.
REQ-010 duration=0 at load SHALL cause note_done on the second cycle after new_note and a return to IDLE, without waiting for a beat.
REQ-011 If new_note coincides with an expiring beat, the load SHALL win, note_done SHALL NOT pulse, and the new note SHALL start.
REQ-012 new_note while PLAYING SHALL abort the current note with no note_done and restart per REQ-003.
REQ-013 sample_req in PLAYING SHALL update phase to (phase + step) mod 2^22, zero-extending step to 22 bits, and pulse sample_valid in the next cycle with phase_addr reflecting the new phase.
REQ-014 sample_req in IDLE or PAUSED SHALL still pulse sample_valid one cycle later, with phase unchanged.
REQ-015 A rest (note=0) SHALL use step=0, so phase_addr is constant; beat counting is unaffected by a rest.
REQ-016 The phase accumulator SHALL wrap silently at 2^22 with no flag.
REQ-017 In IDLE, phase SHALL hold its last value and new_beat SHALL be ignored.
REQ-018 note_done SHALL never be high for two consecutive cycles.
REQ-019 The frequency table SHALL use step(n) = round(440 * 2^((n-49)/12) * 2^22 / 48000) for n=1..63, and step(0)=0; step(49)=38448, step(37)=19224, step(61)=76896.

Reset
REQ-020 rst SHALL force state=IDLE, and beat_cnt, step and phase to 0.
REQ-021 rst SHALL force note_done=0, sample_valid=0, phase_addr=0 and busy=0.
REQ-022 rst SHALL override all other inputs, including new_note in the same cycle.
REQ-023 rst asserted mid-note SHALL abort the note without a note_done pulse.
REQ-024 The first load after reset SHALL behave identically to any other load.

Structure
REQ-025 A shared package SHALL hold the state enum, and the constants NOTE_W=6, DUR_W=7, STEP_W=20, PHASE_W=22 and ADDR_W=10.
REQ-026 The 64-entry table SHALL be a separate sub-module frequency_rom: 6-bit address in, 20-bit step out, one-cycle registered read.
REQ-027 note_player SHALL be drop-in compatible with song_reader's note, duration and new_note outputs, and with song_reader's song_done/new_note handshake.

Verification
REQ-028 Load: note=49, duration=3, play=1, then 3 beats -> note_done exactly once, one cycle after the 3rd beat; busy falls in that same cycle.
REQ-029 Phase: note=49, then 4 sample_req -> phase=153792, phase_addr=37, with 4 sample_valid pulses each one cycle after its request.
REQ-030 Pause: play=0 after beat 1 of a duration=2 note, 5 beats and 3 sample_req while paused -> no note_done and phase unchanged; after play=1, one more beat -> note_done.
REQ-031 Boundary cases:
- duration=0 -> note_done at cycle 2 after load.
- new_note on the same cycle as the expiring beat -> no note_done, and the new duration counts.
- note=0 -> phase_addr constant across 10 sample_req.
REQ-032 Reset mid-note: rst with beat_cnt=5 -> all outputs 0 on the next cycle, and no note_done ever appears for the aborted note.
REQ-033 Integration: song_reader feeds note_player, with beat_generator at STOP=1500 -> each note_done is followed by new_note, songs 0-3 play through to song_done, and no note is skipped.
